// File: rtl/divisor_param.sv
// divisor_param: multi-cycle restoring divider, one quotient bit per clock.
// Unsigned or two's-complement per operation; flags divide-by-zero and overflow.
module divisor_param #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             done,
    output logic             busy,
    output logic             div_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] a_raw;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             zero_f;
    logic             ovf_f;

    logic             sm;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] min_v;
    logic [WIDTH:0]   trial;

    // Operand magnitudes and the trial subtraction for the current step
    always_comb begin
        sm    = SIGNED_EN && signed_mode;
        a_abs = (sm && A[WIDTH-1]) ? -A : A;
        b_abs = (sm && B[WIDTH-1]) ? -B : B;
        min_v = {1'b1, {(WIDTH-1){1'b0}}};
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    end

    // Control FSM plus datapath; results and flags are only written in FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            a_raw    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_f   <= 1'b0;
            ovf_f    <= 1'b0;
            Q        <= '0;
            R        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        quo    <= a_abs;
                        dvs    <= b_abs;
                        rem    <= '0;
                        a_raw  <= A;
                        neg_q  <= sm && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= sm && A[WIDTH-1];
                        zero_f <= (B == '0);
                        ovf_f  <= sm && (A == min_v) && (B == '1);
                        cnt    <= CW'(WIDTH);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                    end
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (zero_f) begin
                        Q        <= '1;
                        R        <= a_raw;
                        div_zero <= 1'b1;
                        ovf      <= 1'b0;
                    end else if (ovf_f) begin
                        Q        <= min_v;
                        R        <= '0;
                        div_zero <= 1'b0;
                        ovf      <= 1'b1;
                    end else begin
                        Q        <= neg_q ? -quo : quo;
                        R        <= neg_r ? -rem : rem;
                        div_zero <= 1'b0;
                        ovf      <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
